mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester and the data (load/store) requester of the RISC-V core.
- Replaces the separate IMEM/DMEM pair so the core can run from one memory.
- Arbitrates with data priority plus a fetch anti-starvation counter.
- Sequences a req/ack transaction to the memory and returns registered read data with a one-cycle valid pulse to the winning requester.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters, data priority with fetch anti-starvation.
// Optional bus timeout abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_IF_WAIT = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                bus_err
);
  localparam int BW = DATA_W / 8;
  localparam int WW = $clog2(MAX_IF_WAIT + 1);
  localparam logic [WW-1:0] IF_WAIT_MAX = WW'(MAX_IF_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       if_wait_q, if_wait_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [BW-1:0]       mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic                bus_err_q, bus_err_d;
  logic                d_win, tmo;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo = tmo_q == TMO_LAST;
  always_comb tmo_d = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo = 1'b0;
`endif

  // Data wins unless fetch has already lost MAX_IF_WAIT grants in a row
  assign d_win = d_req && (!if_req || if_wait_q < IF_WAIT_MAX);

  always_comb begin
    state_d     = state_q;
    if_wait_d   = if_wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (d_win) begin
        state_d     = BUSY_D;
        mem_req_d   = 1'b1;
        mem_we_d    = d_we;
        mem_be_d    = d_be;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
        if_wait_d   = if_req ? if_wait_q + 1'b1 : if_wait_q;
      end else if (if_req) begin
        state_d    = BUSY_IF;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_be_d   = '1;
        mem_addr_d = if_addr;
        if_wait_d  = '0;
      end
    end else if (mem_ack || tmo) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      bus_err_d = !mem_ack;
      if (state_q == BUSY_IF) begin
        if_valid_d = 1'b1;
        if_rdata_d = mem_ack ? mem_rdata : '0;
      end else begin
        d_valid_d = 1'b1;
        d_rdata_d = !mem_ack ? '0 : mem_we_q ? d_rdata_q : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      if_wait_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_wait_q   <= if_wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
    end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a wait-state memory responder and fetch/data requesters.
// Define ARB_TIMEOUT_EN to also exercise the bus timeout abort.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset_n;
  logic        if_req, if_valid, d_req, d_we, d_valid;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_be, mem_be;

  typedef struct packed {logic is_d; logic err; logic [31:0] rdata;} exp_t;
  exp_t        sb[$];
  logic [31:0] mem_m[logic [31:0]];
  logic [31:0] glog[$];
  int          vectors = 0, miscompares = 0;
  bit          resp_en = 1'b1;
  int          resp_wait = 0, wcnt = 0;
  logic        prev_req = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  // Memory responder: acks after resp_wait extra cycles, logs every grant address
  always @(negedge clk) begin
    logic [31:0] tmp;
    if (!reset_n) begin
      mem_ack = 1'b0; wcnt = 0; prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) glog.push_back(mem_addr);
      prev_req = mem_req;
      if (mem_ack) begin
        mem_ack = 1'b0; wcnt = 0;
      end else if (mem_req && resp_en) begin
        if (wcnt == resp_wait) begin
          mem_ack = 1'b1;
          tmp = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
          mem_rdata = tmp;
          if (mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_be[b]) tmp[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_m[mem_addr] = tmp;
          end
        end else wcnt++;
      end
    end
  end

  // Scoreboard monitor: every valid/bus_err pulse pops the next expected completion
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (reset_n) begin
      if (if_valid && d_valid) begin
        vectors++; miscompares++;
        $display("FAIL dual_valid: if_valid=1 d_valid=1, required at most one");
      end
      if (if_valid || d_valid || bus_err) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: if_valid=%0b d_valid=%0b bus_err=%0b, required none",
                   if_valid, d_valid, bus_err);
        end else begin
          e = sb.pop_front();
          act = d_valid ? d_rdata : if_rdata;
          if ({d_valid, if_valid, bus_err, act} !== {e.is_d, !e.is_d, e.err, e.rdata}) begin
            miscompares++;
            $display("FAIL sb_completion: d_valid=%0b if_valid=%0b bus_err=%0b rdata=%h, required d_valid=%0b if_valid=%0b bus_err=%0b rdata=%h",
                     d_valid, if_valid, bus_err, act, e.is_d, !e.is_d, e.err, e.rdata);
          end
        end
      end
    end
  end

  task automatic drive_if(input logic [31:0] a, output bit to);
    if_addr = a; if_req = 1'b1; to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if_valid) begin to = 1'b0; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic drive_d_loads(input int n, input logic [31:0] base, output bit to);
    to = 1'b0;
    for (int k = 0; k < n && !to; k++) begin
      d_we = 1'b0; d_be = 4'hF; d_addr = base + 32'(4 * k); d_req = 1'b1; to = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (d_valid) begin to = 1'b0; break; end
      end
    end
    d_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d completions outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; d_be = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata, bus_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: mem_req=%0b mem_addr=%h if_rdata=%h d_rdata=%h valids=%0b%0b bus_err=%0b, required all 0",
               mem_req, mem_addr, if_rdata, d_rdata, if_valid, d_valid, bus_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    mem_m[32'h10] = 32'h00A00093; resp_wait = 0;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
      miscompares++;
      $display("FAIL fetch_grant: mem_req=%0b we=%0b be=%h addr=%h, required 1 0 f 00000010", mem_req, mem_we, mem_be, mem_addr);
    end
    sb.push_back('{1'b0, 1'b0, 32'h00A00093});
    @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_latency: if_valid=%0b in cycle 2, required 1", if_valid);
    end
    if_req = 1'b0;
    wait_drain("fetch");
  endtask

  task automatic test_simul;
    bit t1, t2;
    mem_m[32'h100] = 32'h11112222; mem_m[32'h20] = 32'h33334444;
    glog.delete();
    sb.push_back('{1'b1, 1'b0, 32'h11112222});
    sb.push_back('{1'b0, 1'b0, 32'h33334444});
    fork
      drive_d_loads(1, 32'h100, t1);
      drive_if(32'h20, t2);
    join
    vectors++;
    if (t1 || t2 || glog.size() != 2 || glog[0] !== 32'h100 || glog[1] !== 32'h20) begin
      miscompares++;
      $display("FAIL simul_order: timeout=%0b%0b grants=%0d first=%h, required grants 00000100 then 00000020",
               t1, t2, glog.size(), glog.size() > 0 ? glog[0] : 32'hx);
    end
    wait_drain("simul");
  endtask

  task automatic test_starve;
    bit t1, t2;
    logic [31:0] want[7];
    bit ok;
    for (int k = 0; k < 6; k++) mem_m[32'h200 + 32'(4 * k)] = 32'h50000000 + 32'(k);
    mem_m[32'h40] = 32'h00000013;
    want = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h40, 32'h210, 32'h214};
    glog.delete();
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h50000000 + 32'(k)});
    sb.push_back('{1'b0, 1'b0, 32'h00000013});
    for (int k = 4; k < 6; k++) sb.push_back('{1'b1, 1'b0, 32'h50000000 + 32'(k)});
    fork
      drive_d_loads(6, 32'h200, t1);
      drive_if(32'h40, t2);
    join
    ok = !t1 && !t2 && glog.size() == 7;
    for (int k = 0; k < 7 && ok; k++) if (glog[k] !== want[k]) ok = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL starve_order: timeout=%0b%0b grants=%0d fifth=%h, required 7 grants with fetch 00000040 fifth",
               t1, t2, glog.size(), glog.size() > 4 ? glog[4] : 32'hx);
    end
    wait_drain("starve");
  endtask

  task automatic test_store;
    int  n = 0, hi = 0;
    bit  bad = 0, to = 1;
    mem_m[32'h300] = 32'h12345678; resp_wait = 3;
    sb.push_back('{1'b1, 1'b0, 32'h50000005});
    d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h300; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (mem_req) begin
        hi++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h300, 32'hDEADBEEF}) bad = 1;
      end
      if (d_valid) begin to = 0; break; end
    end
    d_req = 1'b0; d_we = 1'b0; resp_wait = 0;
    vectors++;
    if (to || bad || hi != 4 || n != 5) begin
      miscompares++;
      $display("FAIL store_hold: timeout=%0b unstable=%0b mem_req_cycles=%0d valid_cycle=%0d, required 0 0 4 5", to, bad, hi, n);
    end
    vectors++;
    if (mem_m[32'h300] !== 32'h1234BEEF) begin
      miscompares++;
      $display("FAIL store_bytes: mem=%h, required 1234beef", mem_m[32'h300]);
    end
    wait_drain("store");
  endtask

  task automatic test_reset_mid;
    bit to = 1;
    resp_en = 1'b0;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400; d_req = 1'b1;
    for (int i = 0; i < 20 && to; i++) begin
      @(negedge clk);
      if (mem_req) to = 0;
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (to || mem_req !== 1'b0 || d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: timeout=%0b mem_req=%0b d_valid=%0b, required 0 0 0", to, mem_req, d_valid);
    end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; resp_en = 1'b1;
    repeat (3) @(negedge clk);
    mem_m[32'h404] = 32'hCAFEF00D;
    sb.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
    drive_d_loads(1, 32'h404, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL reset_recover: d_valid timeout=1, required 0");
    end
    wait_drain("reset_mid");
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n = -1;
    bit to = 1;
    resp_en = 1'b0;
    sb.push_back('{1'b1, 1'b1, 32'h0});
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500; d_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n < 0 && mem_req) n = 0;
      else if (n >= 0) n++;
      if (d_valid) begin to = 0; break; end
    end
    d_req = 1'b0;
    vectors++;
    if (to || n != 64 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: timeout=%0b cycles=%0d mem_req=%0b, required 0 64 0", to, n, mem_req);
    end
    resp_en = 1'b1;
    wait_drain("timeout");
  endtask
`endif

  initial begin
    test_reset;
    test_fetch;
    test_simul;
    test_starve;
    test_store;
    test_reset_mid;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
